// File: rtl/vga_timing_monitor_if.sv
// Sync-pair and status bundle between a VGA timing source and the monitor.
//   hsync_n, vsync_n : active-low syncs from the source, synchronous to the pixel clock
//   line_len         : last measured clocks per line
//   frame_lines      : last measured lines per frame
//   h_locked, locked : horizontal lock / full lock
//   de, x_pos, y_pos : regenerated active-video enable and coordinates
//   timing_error     : one-cycle pulse on mismatch or timeout
interface vga_timing_monitor_if;
  logic        hsync_n;
  logic        vsync_n;
  logic [15:0] line_len;
  logic [15:0] frame_lines;
  logic        h_locked;
  logic        locked;
  logic        de;
  logic [15:0] x_pos;
  logic [15:0] y_pos;
  logic        timing_error;

  modport master (
    output hsync_n, vsync_n,
    input  line_len, frame_lines, h_locked, locked, de, x_pos, y_pos, timing_error
  );

  modport slave (
    input  hsync_n, vsync_n,
    output line_len, frame_lines, h_locked, locked, de, x_pos, y_pos, timing_error
  );
endinterface

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing monitor. Measures line length and frame height from
// an incoming hsync/vsync pair, declares lock after consecutive in-spec lines
// and frames, and regenerates pixel coordinates plus a data-enable.
//   clk_25MHz : pixel clock, rising edge
//   reset     : asynchronous, active-high
//   bus       : slave side of vga_timing_monitor_if (syncs in, status out)
module vga_timing_monitor #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_LINES  = 4,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input logic                 clk_25MHz,
  input logic                 reset,
  vga_timing_monitor_if.slave bus
);
  localparam logic [15:0] H_TOT  = 16'(H_TOTAL);
  localparam logic [15:0] H_MAX  = 16'(2 * H_TOTAL);
  localparam logic [15:0] V_TOT  = 16'(V_TOTAL);
  localparam logic [15:0] V_MAX  = 16'(2 * V_TOTAL);
  localparam logic [15:0] HA_BEG = 16'(H_SYNC + H_BP);
  localparam logic [15:0] HA_END = 16'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [15:0] VA_BEG = 16'(V_SYNC + V_BP);
  localparam logic [15:0] VA_END = 16'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [15:0] H_LOCK = 16'(LOCK_LINES);
  localparam logic [15:0] V_LOCK = 16'(LOCK_FRAMES);

  logic        hs_prev_q, hs_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic [15:0] h_cnt_q, h_cnt_d;
  logic [15:0] v_cnt_q, v_cnt_d;
  logic        h_seen_q, h_seen_d;
  logic        v_seen_q, v_seen_d;
  logic [15:0] h_match_q, h_match_d;
  logic [15:0] v_match_q, v_match_d;
  logic        h_locked_q, h_locked_d;
  logic        v_locked_q, v_locked_d;
  logic [15:0] line_len_q, line_len_d;
  logic [15:0] frame_lines_q, frame_lines_d;
  logic        err_q, err_d;

  logic        hs_fall, vs_fall;
  logic [15:0] line_m, frame_n;
  logic        h_meas, h_good, h_bad;
  logic        v_meas, v_good, v_bad;
  logic        h_to, v_to;
  logic        h_clr, v_clr;
  logic        h_act, v_act, de_w;

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      h_match_q     <= '0;
      v_match_q     <= '0;
      h_locked_q    <= 1'b0;
      v_locked_q    <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      err_q         <= 1'b0;
    end else begin
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_seen_q      <= h_seen_d;
      v_seen_q      <= v_seen_d;
      h_match_q     <= h_match_d;
      v_match_q     <= v_match_d;
      h_locked_q    <= h_locked_d;
      v_locked_q    <= v_locked_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    hs_prev_d = bus.hsync_n;
    vs_prev_d = bus.vsync_n;
    hs_fall   = hs_prev_q & ~bus.hsync_n;
    vs_fall   = vs_prev_q & ~bus.vsync_n;

    line_m  = h_cnt_q + 16'd1;
    frame_n = v_cnt_q + 16'd1;

    h_meas = hs_fall & h_seen_q;
    h_good = h_meas & (line_m == H_TOT);
    h_bad  = h_meas & (line_m != H_TOT);
    v_meas = vs_fall & v_seen_q;
    v_good = v_meas & (frame_n == V_TOT) & h_locked_q;
    v_bad  = v_meas & ~v_good;

    // Timeouts fire only on the transition into saturation, so a stuck sync
    // produces exactly one error until the counter is reloaded.
    h_to = ~hs_fall & (h_cnt_q == H_MAX - 16'd1);
    v_to = ~vs_fall & hs_fall & (v_cnt_q == V_MAX - 16'd1);

    // A horizontal fault invalidates vertical lock as well.
    h_clr = h_bad | h_to;
    v_clr = h_clr | v_bad | v_to;

    if (hs_fall) begin
      h_cnt_d = '0;
    end else if (h_cnt_q < H_MAX) begin
      h_cnt_d = h_cnt_q + 16'd1;
    end else begin
      h_cnt_d = h_cnt_q;
    end

    // vs_fall wins over a coincident hs_fall so the frame starts at line 0.
    if (vs_fall) begin
      v_cnt_d = '0;
    end else if (hs_fall && (v_cnt_q < V_MAX)) begin
      v_cnt_d = v_cnt_q + 16'd1;
    end else begin
      v_cnt_d = v_cnt_q;
    end

    h_seen_d = (h_seen_q | hs_fall) & ~h_to;
    v_seen_d = (v_seen_q | vs_fall) & ~(h_to | v_to);

    line_len_d    = h_meas ? line_m : line_len_q;
    frame_lines_d = v_meas ? frame_n : frame_lines_q;

    h_match_d  = h_match_q;
    h_locked_d = h_locked_q;
    if (h_good && (h_match_q < H_LOCK)) begin
      h_match_d = h_match_q + 16'd1;
    end
    if (h_good && (h_match_d == H_LOCK)) begin
      h_locked_d = 1'b1;
    end
    if (h_clr) begin
      h_match_d  = '0;
      h_locked_d = 1'b0;
    end

    v_match_d  = v_match_q;
    v_locked_d = v_locked_q;
    if (v_good && (v_match_q < V_LOCK)) begin
      v_match_d = v_match_q + 16'd1;
    end
    if (v_good && (v_match_d == V_LOCK)) begin
      v_locked_d = 1'b1;
    end
    if (v_clr) begin
      v_match_d  = '0;
      v_locked_d = 1'b0;
    end

    err_d = h_bad | v_bad | h_to | v_to;
  end

  always_comb begin
    h_act = (h_cnt_q >= HA_BEG) && (h_cnt_q < HA_END);
    v_act = (v_cnt_q >= VA_BEG) && (v_cnt_q < VA_END);
    de_w  = h_locked_q & v_locked_q & h_act & v_act;
  end

  assign bus.line_len     = line_len_q;
  assign bus.frame_lines  = frame_lines_q;
  assign bus.h_locked     = h_locked_q;
  assign bus.locked       = h_locked_q & v_locked_q;
  assign bus.de           = de_w;
  assign bus.x_pos        = de_w ? (h_cnt_q - HA_BEG) : '0;
  assign bus.y_pos        = de_w ? (v_cnt_q - VA_BEG) : '0;
  assign bus.timing_error = err_q;
endmodule

// File: tb/tb_vga_timing_monitor.sv
// Testbench for vga_timing_monitor using a reduced 40x14 raster so whole
// frames fit in a short run. Per-pixel de/x/y/locked expectations are derived
// from the raster position being driven and checked one cycle later.
module tb_vga_timing_monitor;
  localparam int unsigned TB_HT  = 40;
  localparam int unsigned TB_HS  = 4;
  localparam int unsigned TB_HB  = 6;
  localparam int unsigned TB_HA  = 24;
  localparam int unsigned TB_VT  = 14;
  localparam int unsigned TB_VS  = 2;
  localparam int unsigned TB_VB  = 3;
  localparam int unsigned TB_VA  = 8;
  localparam int unsigned HOFF   = TB_HS + TB_HB;
  localparam int unsigned VOFF   = TB_VS + TB_VB;
  localparam int unsigned NOLINE = 999;
  localparam int unsigned NVEC   = 13;

  typedef struct {
    int unsigned len;
    logic [15:0] exp_len;
    logic        exp_err;
    logic        exp_hl;
  } vec_t;

  typedef struct {
    logic        locked;
    logic        de;
    logic [15:0] x;
    logic [15:0] y;
    int unsigned vl;
    int unsigned p;
  } sb_t;

  typedef struct {
    logic [15:0] line_len;
    logic [15:0] frame_lines;
    logic        err;
    logic        hl;
    logic        lk;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int de_cnt = 0;
  int first_err_k = 0;

  bit   sb_en = 1'b0;
  logic sb_lock = 1'b0;
  sb_t  sbq[$];

  snap_t lsnap, fsnap, psnap;
  vec_t  tbl[NVEC];

  vga_timing_monitor_if bus ();

  vga_timing_monitor #(
    .H_TOTAL    (TB_HT),
    .H_SYNC     (TB_HS),
    .H_BP       (TB_HB),
    .H_ACTIVE   (TB_HA),
    .V_TOTAL    (TB_VT),
    .V_SYNC     (TB_VS),
    .V_BP       (TB_VB),
    .V_ACTIVE   (TB_VA),
    .LOCK_LINES (4),
    .LOCK_FRAMES(2)
  ) dut (
    .clk_25MHz(clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #20 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic snap_t take_snap();
    snap_t s;
    s.line_len    = bus.line_len;
    s.frame_lines = bus.frame_lines;
    s.err         = bus.timing_error;
    s.hl          = bus.h_locked;
    s.lk          = bus.locked;
    return s;
  endfunction

  // Called at a falling edge: drive one pixel, let the next rising edge sample
  // it, then compare the outputs at the following falling edge.
  task automatic step(input logic hs, input logic vs, input int unsigned vl, input int unsigned p);
    sb_t e;
    bus.hsync_n = hs;
    bus.vsync_n = vs;
    if (sb_en) begin
      e.locked = sb_lock;
      e.de     = sb_lock && (vl >= VOFF) && (vl < VOFF + TB_VA) && (p >= HOFF) && (p < HOFF + TB_HA);
      e.x      = e.de ? 16'(p - HOFF) : 16'd0;
      e.y      = e.de ? 16'(vl - VOFF) : 16'd0;
      e.vl     = vl;
      e.p      = p;
      sbq.push_back(e);
    end
    @(negedge clk);
    if (bus.timing_error === 1'b1) err_cnt++;
    if (bus.de === 1'b1) de_cnt++;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      checks++;
      if (bus.de !== e.de || bus.x_pos !== e.x || bus.y_pos !== e.y || bus.locked !== e.locked) begin
        errors++;
        $display("FAIL pix_l%0d_p%0d: got de=%0b x=%0d y=%0d locked=%0b expected de=%0b x=%0d y=%0d locked=%0b",
                 e.vl, e.p, bus.de, bus.x_pos, bus.y_pos, bus.locked, e.de, e.x, e.y, e.locked);
      end
    end
  endtask

  task automatic drive_line(input int unsigned len, input int unsigned vl, input bit fs, input bit ps);
    for (int unsigned p = 0; p < len; p++) begin
      step((p < TB_HS) ? 1'b0 : 1'b1, (vl < TB_VS) ? 1'b0 : 1'b1, vl, p);
      if (p == 0) begin
        lsnap = take_snap();
        if (fs) fsnap = lsnap;
        if (ps) psnap = lsnap;
      end
    end
  endtask

  task automatic drive_frame(input int unsigned nlines, input int unsigned long_idx,
                             input int unsigned long_len, input int unsigned probe);
    for (int unsigned l = 0; l < nlines; l++) begin
      drive_line((l == long_idx) ? long_len : TB_HT, l, (l == 0), (l == probe));
    end
  endtask

  task automatic do_reset(input string tag);
    sb_en = 1'b0;
    sbq.delete();
    bus.hsync_n = 1'b1;
    bus.vsync_n = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, "_rst_line_len"}, 32'(bus.line_len), 32'd0);
    chk({tag, "_rst_frame_lines"}, 32'(bus.frame_lines), 32'd0);
    chk({tag, "_rst_flags"}, {28'd0, bus.h_locked, bus.locked, bus.de, bus.timing_error}, 32'd0);
    chk({tag, "_rst_xy"}, {bus.x_pos, bus.y_pos}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {line length driven, line_len / timing_error / h_locked seen at the start of this line}
    tbl[0]  = '{TB_HT,     16'd0,  1'b0, 1'b0};
    tbl[1]  = '{TB_HT,     16'd40, 1'b0, 1'b0};
    tbl[2]  = '{TB_HT,     16'd40, 1'b0, 1'b0};
    tbl[3]  = '{TB_HT,     16'd40, 1'b0, 1'b0};
    tbl[4]  = '{TB_HT + 1, 16'd40, 1'b0, 1'b1};
    tbl[5]  = '{TB_HT,     16'd41, 1'b1, 1'b0};
    tbl[6]  = '{TB_HT - 1, 16'd40, 1'b0, 1'b0};
    tbl[7]  = '{TB_HT,     16'd39, 1'b1, 1'b0};
    tbl[8]  = '{TB_HT,     16'd40, 1'b0, 1'b0};
    tbl[9]  = '{TB_HT,     16'd40, 1'b0, 1'b0};
    tbl[10] = '{TB_HT,     16'd40, 1'b0, 1'b0};
    tbl[11] = '{TB_HT,     16'd40, 1'b0, 1'b1};
    tbl[12] = '{TB_HT,     16'd40, 1'b0, 1'b1};

    bus.hsync_n = 1'b1;
    bus.vsync_n = 1'b1;
    @(negedge clk);

    // Line measurement and horizontal lock, vsync idle.
    do_reset("a");
    for (int i = 0; i < int'(NVEC); i++) begin
      drive_line(tbl[i].len, NOLINE, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_line_len", i), 32'(lsnap.line_len), 32'(tbl[i].exp_len));
      chk($sformatf("tbl%0d_err", i), 32'(lsnap.err), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_h_locked", i), 32'(lsnap.hl), 32'(tbl[i].exp_hl));
    end

    // Nominal acquisition from reset, then two fully checked locked frames.
    do_reset("b");
    err_cnt = 0;
    drive_frame(TB_VT, NOLINE, 0, NOLINE);
    chk("f0_frame_lines", 32'(fsnap.frame_lines), 32'd0);
    drive_frame(TB_VT, NOLINE, 0, NOLINE);
    chk("f1_frame_lines", 32'(fsnap.frame_lines), 32'd14);
    chk("f1_h_locked", 32'(fsnap.hl), 32'd1);
    chk("f1_locked", 32'(fsnap.lk), 32'd0);
    sb_en = 1'b1;
    sb_lock = 1'b1;
    for (int f = 2; f < 4; f++) begin
      de_cnt = 0;
      drive_frame(TB_VT, NOLINE, 0, NOLINE);
      chk($sformatf("f%0d_locked", f), 32'(fsnap.lk), 32'd1);
      chk($sformatf("f%0d_de_count", f), 32'(de_cnt), 32'(TB_HA * TB_VA));
    end
    sb_en = 1'b0;
    chk("b_err_count", 32'(err_cnt), 32'd0);

    // One line one clock long while locked.
    err_cnt = 0;
    drive_frame(TB_VT, 6, TB_HT + 1, 7);
    chk("c_long_line_len", 32'(psnap.line_len), 32'd41);
    chk("c_long_err", 32'(psnap.err), 32'd1);
    chk("c_long_h_locked", 32'(psnap.hl), 32'd0);
    chk("c_long_locked", 32'(psnap.lk), 32'd0);
    drive_frame(TB_VT, NOLINE, 0, NOLINE);
    chk("c_f5_h_locked", 32'(fsnap.hl), 32'd1);
    chk("c_f5_locked", 32'(fsnap.lk), 32'd0);
    chk("c_err_count", 32'(err_cnt), 32'd1);

    // Frame one line too tall while locked.
    err_cnt = 0;
    sb_en = 1'b1;
    sb_lock = 1'b1;
    de_cnt = 0;
    drive_frame(TB_VT + 1, NOLINE, 0, NOLINE);
    sb_en = 1'b0;
    chk("d_f6_locked", 32'(fsnap.lk), 32'd1);
    chk("d_f6_de_count", 32'(de_cnt), 32'(TB_HA * TB_VA));
    drive_frame(TB_VT, NOLINE, 0, NOLINE);
    chk("d_tall_frame_lines", 32'(fsnap.frame_lines), 32'd15);
    chk("d_tall_err", 32'(fsnap.err), 32'd1);
    chk("d_tall_locked", 32'(fsnap.lk), 32'd0);
    chk("d_tall_h_locked", 32'(fsnap.hl), 32'd1);
    drive_frame(TB_VT, NOLINE, 0, NOLINE);
    chk("d_err_count", 32'(err_cnt), 32'd1);
    drive_frame(TB_VT, NOLINE, 0, NOLINE);
    chk("d_relock", 32'(fsnap.lk), 32'd1);

    // hsync stuck high: h_cnt ends at 39, so it reaches 2*H_TOTAL on step 41.
    err_cnt = 0;
    first_err_k = 0;
    for (int k = 1; k <= 100; k++) begin
      step(1'b1, 1'b1, NOLINE, 0);
      if (bus.timing_error === 1'b1 && first_err_k == 0) first_err_k = k;
    end
    chk("e_timeout_pulses", 32'(err_cnt), 32'd1);
    chk("e_timeout_step", 32'(first_err_k), 32'd41);
    chk("e_flags_after", {29'd0, bus.h_locked, bus.locked, bus.de}, 32'd0);
    chk("e_xy_after", {bus.x_pos, bus.y_pos}, 32'd0);
    err_cnt = 0;
    drive_line(TB_HT, NOLINE, 1'b0, 1'b0);
    chk("e_first_edge_line_len", 32'(lsnap.line_len), 32'd40);
    chk("e_first_edge_err", 32'(lsnap.err), 32'd0);
    drive_line(TB_HT, NOLINE, 1'b0, 1'b0);
    chk("e_second_edge_line_len", 32'(lsnap.line_len), 32'd40);
    drive_frame(TB_VT, NOLINE, 0, 2);
    chk("e_f10_frame_lines", 32'(fsnap.frame_lines), 32'd14);
    chk("e_f10_h_locked_l2", 32'(psnap.hl), 32'd1);
    drive_frame(TB_VT, NOLINE, 0, NOLINE);
    chk("e_f11_locked", 32'(fsnap.lk), 32'd0);
    chk("e_err_count", 32'(err_cnt), 32'd0);

    // Reset in the middle of active video.
    sb_en = 1'b1;
    sb_lock = 1'b1;
    for (int unsigned l = 0; l < 6; l++) begin
      drive_line(TB_HT, l, (l == 0), 1'b0);
    end
    chk("g_f12_locked", 32'(fsnap.lk), 32'd1);
    for (int unsigned p = 0; p < 16; p++) begin
      step((p < TB_HS) ? 1'b0 : 1'b1, 1'b1, 6, p);
    end
    sb_en = 1'b0;
    chk("g_pre_reset_de", 32'(bus.de), 32'd1);
    rst = 1'b1;
    #1;
    chk("g_async_de", 32'(bus.de), 32'd0);
    chk("g_async_xy", {bus.x_pos, bus.y_pos}, 32'd0);
    chk("g_async_locks", {30'd0, bus.h_locked, bus.locked}, 32'd0);
    bus.hsync_n = 1'b1;
    bus.vsync_n = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive_frame(TB_VT, NOLINE, 0, NOLINE);
    drive_frame(TB_VT, NOLINE, 0, NOLINE);
    chk("g_r1_locked", 32'(fsnap.lk), 32'd0);
    chk("g_r1_frame_lines", 32'(fsnap.frame_lines), 32'd14);
    drive_frame(TB_VT, NOLINE, 0, NOLINE);
    chk("g_r2_locked", 32'(fsnap.lk), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_monitor.md
# vga_timing_monitor

Receive-side counterpart of the horizontal/vertical timing generators: watches an incoming 640x480@60 VGA sync pair on the 25 MHz pixel clock and measures the line length and frame height. It declares lock after consecutive in-spec lines and frames, and regenerates pixel coordinates and a data-enable for downstream capture or self-check logic. It sits on the sink side of the display path and doubles as an on-chip checker for the local sync generators.

## Interface
- H_TOTAL, 800, expected pixel clocks per line
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, active pixels per line
- V_TOTAL, 525, expected lines per frame
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch
- V_ACTIVE, 480, active lines per frame
- LOCK_LINES, 4, consecutive good lines for h_locked
- LOCK_FRAMES, 2, consecutive good frames for v_locked
- clk_25MHz  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- hsync_n  in  1  horizontal sync, active-low, synchronous to clk_25MHz
- vsync_n  in  1  vertical sync, active-low, synchronous to clk_25MHz
- line_len  out  16  last measured clocks per line
- frame_lines  out  16  last measured lines per frame
- h_locked  out  1  horizontal lock
- locked  out  1  h_locked & v_locked
- de  out  1  active-video enable (only while locked)
- x_pos  out  16  active pixel column, 0..H_ACTIVE-1, 0 when de=0
- y_pos  out  16  active line, 0..V_ACTIVE-1, 0 when de=0
- timing_error  out  1  one-cycle pulse on mismatch or timeout

## Operation
- Registers hs_prev and vs_prev hold the previous samples and reset to 1. hs_fall = hs_prev & ~hsync_n; vs_fall = vs_prev & ~vsync_n.
- h_cnt (16b): on hs_fall it loads 0, otherwise it increments, saturating at 2*H_TOTAL.
- h_seen flag: set by the first hs_fall after reset or timeout. A measurement is made only on an hs_fall with h_seen=1.
- Line measurement m = h_cnt+1.
  - On measurement: line_len <= m.
  - If m == H_TOTAL: h_match increments, saturating at LOCK_LINES; h_locked sets when h_match reaches LOCK_LINES.
  - Else: h_match <= 0, h_locked <= 0, v_match <= 0, v_locked <= 0, and timing_error pulses.
- v_cnt (16b): increments on each hs_fall not coincident with vs_fall. On vs_fall it loads 0, including when vs_fall and hs_fall occur in the same cycle. It saturates at 2*V_TOTAL.
- v_seen flag: set by the first vs_fall after reset or timeout.
- Frame measurement n = v_cnt+1, taken on vs_fall with v_seen=1.
  - On measurement: frame_lines <= n.
  - If n == V_TOTAL and h_locked: v_match increments, saturating at LOCK_FRAMES; v_locked sets at LOCK_FRAMES.
  - Else: v_match <= 0, v_locked <= 0, and timing_error pulses.
- Horizontal timeout: the cycle h_cnt reaches 2*H_TOTAL clears h_seen, v_seen, both match counters and both lock flags, and pulses timing_error once. It does not pulse again until h_cnt is reloaded.
- Vertical timeout: the cycle v_cnt reaches 2*V_TOTAL does the same, but clears only the vertical state (v_seen, v_match, v_locked).
- Coordinates are combinational from registered state:
  - de = locked & (h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE)) & (v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE)).
  - x_pos = h_cnt-(H_SYNC+H_BP) and y_pos = v_cnt-(V_SYNC+V_BP) when de=1; both are 0 otherwise.
- Simultaneous horizontal mismatch and vertical events in one cycle produce a single timing_error pulse. Clears take priority over increments.

## Timing
- Reset values:
  - h_cnt=0, v_cnt=0, line_len=0, frame_lines=0.
  - All flags and match counters 0; h_locked=0, locked=0, de=0, x_pos=0, y_pos=0, timing_error=0.
- Edge cycle E is the first clock that samples hsync_n=0 after a 1.
  - h_cnt=0 in E+1.
  - line_len, h_locked and timing_error update at E+1 (1-cycle latency).
- With nominal timing, first de=1 with x_pos=0 occurs at E+145. Last active pixel (x_pos=639) is at E+784.
- vsync edge in cycle F: frame_lines, v_locked, locked update at F+1; v_cnt=0 at F+1.
- Earliest lock from reset with clean input:
  - h_locked after 1+LOCK_LINES hsync edges.
  - locked after 1+LOCK_FRAMES vsync edges, counting only frames that end with h_locked=1.
- Reset asserted mid-frame clears everything within the same cycle, asynchronously. Re-acquisition restarts from the first edges after release.

## Test plan
- Nominal 800x525 stimulus from reset:
  - line_len=800 after the second hsync edge.
  - h_locked=1 after the 5th edge.
  - locked=1 after the 3rd vsync edge.
  - Exactly 640x480 de cycles per frame, with x_pos 0..639 and y_pos 0..479.
- One 801-clock line while locked: line_len=801, a single timing_error pulse, h_locked=0 and locked=0. Relock after 4 good lines (h) and 2 good frames.
- Frame of 526 lines while locked: frame_lines=526, timing_error pulse, locked=0, h_locked stays 1.
- hsync_n held high for 2000 clocks while locked: timing_error pulses exactly once at h_cnt=1600, all lock flags drop, de=0. The next edge only sets h_seen; no measurement, no error.
- vsync_n and hsync_n falling in the same cycle: v_cnt=0 next cycle, not 1. frame_lines=525 on nominal input.
- Reset pulse mid-active-video: de, x_pos, y_pos and locked are 0 immediately. Full re-lock follows nominal counts after release.
